button_sequence_capture: RTL and testbench

- Captures the player's button presses for one round after the LED pattern playback finishes.
- Per button: synchronise, debounce and rising-edge detect; then records each valid press index (0-7) into ordered slots until the level-dependent target count (8/12/16) is reached.
- Drives the per-slot answer bus and a held end_signal consumed by the round compare / round-advance logic in the game manager.

---
 rtl/button_sequence_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_button_sequence_capture.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_sequence_capture.sv
// button_sequence_capture
//   Records the player's button presses for one round, after the LED pattern
//   playback has finished. Each raw button is synchronised, debounced and
//   rising-edge detected. Every valid single-button press stores that button's
//   index (0-7) into the next ordered slot. When the level-dependent target
//   count (8/12/16) is reached, capture stops and end_signal is held high.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   enable       in   capture permitted; low returns the block to IDLE
//   level[2:0]   in   one-hot level: 001 -> 8, 010 -> 12, 100 -> 16 presses
//   botton[7:0]  in   raw asynchronous buttons, active-high, bit i = button i+1
//   seq_flat     out  slot k at [k*IDX_W +: IDX_W], slot 0 = first press
//   count[4:0]   out  number of slots filled
//   end_signal   out  high while the target count has been reached
//   multi_press  out  one-cycle pulse for a rejected simultaneous press
//   led_echo     out  debounced button state
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | slots/count cleared, waiting for enable with a valid level
//   S_ARM     | target latched, waiting for every button to be released
//   S_CAPTURE | recording single presses into slots
//   S_DONE    | target reached, slots frozen, end_signal high

module button_sequence_capture #(
  parameter int MAX_LEN         = 16,
  parameter int IDX_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               level,
  input  logic [7:0]               botton,
  output logic [MAX_LEN*IDX_W-1:0] seq_flat,
  output logic [4:0]               count,
  output logic                     end_signal,
  output logic                     multi_press,
  output logic [7:0]               led_echo
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       db_q, db_d;
  logic [7:0]       db_prev_q;
  logic [CNT_W-1:0] dbc_q [8];
  logic [CNT_W-1:0] dbc_d [8];

  logic [4:0]               target_q, target_d;
  logic [4:0]               count_q, count_d;
  logic [MAX_LEN*IDX_W-1:0] seq_q, seq_d;
  logic                     multi_q, multi_d;

  logic [7:0]       pe;
  logic             pe_single;
  logic             pe_multi;
  logic [IDX_W-1:0] pe_idx;
  logic             lvl_valid;
  logic [4:0]       lvl_target;

  logic wr_en;
  logic clear_en;
  logic multi_set;
  logic target_ld;

  // ---------------------------------------------------------------------------
  // Input path: synchroniser and per-bit debounce.
  // The counter tracks how many consecutive samples the synchronised value
  // has disagreed with db; db flips on the next disagreeing sample once the
  // count has reached DEBOUNCE_CYCLES.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 8; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          db_d[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 8; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      sync1_q   <= botton;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 8; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
    end
  end

  // Press events. A new edge while another button is already held still
  // yields a one-hot pe, so it counts as a single press.
  assign pe        = db_q & ~db_prev_q;
  assign pe_single = ($countones(pe) == 1);
  assign pe_multi  = ($countones(pe) > 1);

  always_comb begin
    pe_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (pe[i]) pe_idx = IDX_W'(i);
    end
  end

  always_comb begin
    lvl_valid  = 1'b1;
    lvl_target = 5'd0;
    case (level)
      3'b001:  lvl_target = 5'd8;
      3'b010:  lvl_target = 5'd12;
      3'b100:  lvl_target = 5'd16;
      default: lvl_valid  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable && lvl_valid) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable)          state_d = S_IDLE;
        else if (db_q == '0)  state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!enable) state_d = S_IDLE;
        else if (pe_single && ((count_q + 5'd1) == target_q)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    end_signal = (state_q == S_DONE);
    target_ld  = (state_q == S_IDLE) && enable && lvl_valid;
    // Dropping enable clears the slots on the same edge that returns to IDLE.
    clear_en   = (state_q == S_IDLE) || !enable;
    wr_en      = (state_q == S_CAPTURE) && enable && pe_single;
    multi_set  = (state_q == S_CAPTURE) && enable && pe_multi;
  end

  // ---------------------------------------------------------------------------
  // Slot / count datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    seq_d    = seq_q;
    multi_d  = multi_set;
    if (target_ld) target_d = lvl_target;
    if (clear_en) begin
      count_d = '0;
      seq_d   = '0;
    end else if (wr_en) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (count_q == 5'(k)) seq_d[k*IDX_W +: IDX_W] = pe_idx;
      end
      count_d = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      multi_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      multi_q  <= multi_d;
    end
  end

  assign seq_flat    = seq_q;
  assign count       = count_q;
  assign multi_press = multi_q;
  assign led_echo    = db_q;

endmodule

// File: tb/tb_button_sequence_capture.sv
module tb_button_sequence_capture;

  localparam int MAX_LEN = 16;
  localparam int IDX_W   = 3;
  localparam int DC      = 4;
  localparam int SW      = MAX_LEN * IDX_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    level;
  logic [7:0]    botton;
  logic [SW-1:0] seq_flat;
  logic [4:0]    count;
  logic          end_signal;
  logic          multi_press;
  logic [7:0]    led_echo;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: ordered list of accepted button indices and the target.
  int model_q[$];
  int model_target;

  button_sequence_capture #(
    .MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .level(level), .botton(botton),
    .seq_flat(seq_flat), .count(count), .end_signal(end_signal),
    .multi_press(multi_press), .led_echo(led_echo)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int target_of(input logic [2:0] lv);
    case (lv)
      3'b001:  return 8;
      3'b010:  return 12;
      3'b100:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [SW-1:0] model_seq();
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < model_q.size(); i++) v[i*IDX_W +: IDX_W] = 3'(model_q[i]);
    return v;
  endfunction

  function automatic logic model_end();
    return (model_target != 0) && (model_q.size() == model_target);
  endfunction

  // Clean single press; the model accepts it while slots remain.
  task automatic press(input int b, input int hold, input int rel);
    botton = 8'(1 << b);
    tick(hold);
    botton = '0;
    tick(rel);
    if (model_q.size() < model_target) model_q.push_back(b);
  endtask

  task automatic rand_press();
    press(int'($urandom_range(0, 7)), int'($urandom_range(6, 14)),
          int'($urandom_range(8, 14)));
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; level = '0; botton = '0;
    tick();
    rst = 1'b0;
    model_q.delete();
    model_target = 0;
  endtask

  task automatic start(input logic [2:0] lv);
    level = lv;
    enable = 1'b1;
    model_target = target_of(lv);
    tick(3);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({seq_flat, count, end_signal} !== '0) begin
      n_fail++;
      $display("FAIL reset_slots: got seq=%h count=%0d end=%b want all 0", seq_flat, count, end_signal);
    end
    n_cmp++;
    if ({multi_press, led_echo} !== '0) begin
      n_fail++;
      $display("FAIL reset_misc: got multi=%b led=%h want 0", multi_press, led_echo);
    end
  endtask

  task automatic test_sequence();
    int btn[8] = '{2, 0, 7, 1, 1, 4, 6, 3};
    do_reset();
    start(3'b001);
    for (int i = 0; i < 7; i++) press(btn[i], 10, 10);
    botton = 8'(1 << btn[7]);
    tick(DC + 3);
    n_cmp++;
    if (end_signal !== 1'b0 || count !== 5'd7) begin
      n_fail++;
      $display("FAIL seq_before_last: got end=%b count=%0d want 0/7", end_signal, count);
    end
    tick();
    n_cmp++;
    if (end_signal !== 1'b1 || count !== 5'd8) begin
      n_fail++;
      $display("FAIL seq_last_edge: got end=%b count=%0d want 1/8", end_signal, count);
    end
    botton = '0;
    tick(10);
    model_q.push_back(btn[7]);
    n_cmp++;
    if (seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL seq_slots: got %h want %h", seq_flat, model_seq());
    end
  endtask

  task automatic test_glitch_latency();
    do_reset();
    start(3'b001);
    botton = 8'h01;
    tick(3);
    botton = '0;
    tick(12);
    n_cmp++;
    if (count !== 5'd0 || led_echo !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch: got count=%0d led=%h want 0/00", count, led_echo);
    end
    botton = 8'h01;
    tick(DC + 3);
    n_cmp++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL latency_early: got count=%0d want 0", count);
    end
    tick();
    n_cmp++;
    if (count !== 5'd1 || seq_flat !== '0 || led_echo !== 8'h01) begin
      n_fail++;
      $display("FAIL latency_edge: got count=%0d seq=%h led=%h want 1/0/01", count, seq_flat, led_echo);
    end
    tick(12);
    botton = '0;
    tick(10);
  endtask

  task automatic test_arm_hold();
    do_reset();
    botton = 8'h02;
    tick(10);
    level = 3'b010;
    enable = 1'b1;
    model_target = 12;
    tick(20);
    n_cmp++;
    if (count !== 5'd0 || led_echo !== 8'h02) begin
      n_fail++;
      $display("FAIL arm_held: got count=%0d led=%h want 0/02", count, led_echo);
    end
    botton = '0;
    tick(10);
    press(5, 10, 10);
    n_cmp++;
    if (count !== 5'd1 || seq_flat[2:0] !== 3'd5) begin
      n_fail++;
      $display("FAIL arm_first: got count=%0d slot0=%0d want 1/5", count, seq_flat[2:0]);
    end
    for (int i = 0; i < 11; i++) rand_press();
    n_cmp++;
    if (count !== 5'd12 || end_signal !== 1'b1 || seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL arm_full: got count=%0d end=%b seq=%h want 12/1/%h", count, end_signal, seq_flat, model_seq());
    end
  endtask

  task automatic test_multi();
    int pulses;
    do_reset();
    start(3'b100);
    botton = 8'b0000_1010;
    pulses = 0;
    repeat (15) begin
      tick();
      if (multi_press === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL multi_pulse: got pulses=%0d count=%0d want 1/0", pulses, count);
    end
    botton = '0;
    tick(12);
    press(3, 10, 10);
    n_cmp++;
    if (count !== 5'd1 || seq_flat[2:0] !== 3'd3) begin
      n_fail++;
      $display("FAIL multi_after: got count=%0d slot0=%0d want 1/3", count, seq_flat[2:0]);
    end
    botton = 8'h01;
    tick(10);
    botton = 8'h05;
    tick(10);
    botton = '0;
    tick(10);
    model_q.push_back(0);
    model_q.push_back(2);
    n_cmp++;
    if (count !== 5'd3 || seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL overlap: got count=%0d seq=%h want 3/%h", count, seq_flat, model_seq());
    end
  endtask

  task automatic test_abort();
    do_reset();
    start(3'b100);
    for (int i = 0; i < 9; i++) rand_press();
    n_cmp++;
    if (count !== 5'd9 || seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL abort_pre: got count=%0d seq=%h want 9/%h", count, seq_flat, model_seq());
    end
    enable = 1'b0;
    tick();
    model_q.delete();
    n_cmp++;
    if (count !== 5'd0 || seq_flat !== '0 || end_signal !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got count=%0d seq=%h end=%b want 0/0/0", count, seq_flat, end_signal);
    end
    start(3'b100);
    rand_press();
    rand_press();
    n_cmp++;
    if (count !== 5'd2 || seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL reenable: got count=%0d seq=%h want 2/%h", count, seq_flat, model_seq());
    end
    enable = 1'b0;
    tick();
    model_q.delete();
    start(3'b011);
    press(4, 10, 10);
    n_cmp++;
    if (count !== 5'd0 || end_signal !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_level: got count=%0d end=%b want 0/0", count, end_signal);
    end
  endtask

  task automatic test_done_freeze();
    logic [SW-1:0] frozen;
    do_reset();
    start(3'b001);
    for (int i = 0; i < 3; i++) rand_press();
    level = 3'b100;
    for (int i = 0; i < 5; i++) rand_press();
    n_cmp++;
    if (count !== 5'd8 || end_signal !== 1'b1 || seq_flat !== model_seq()) begin
      n_fail++;
      $display("FAIL done_reach: got count=%0d end=%b seq=%h want 8/1/%h", count, end_signal, seq_flat, model_seq());
    end
    frozen = model_seq();
    for (int i = 0; i < 3; i++) rand_press();
    n_cmp++;
    if (count !== 5'd8 || end_signal !== 1'b1 || seq_flat !== frozen) begin
      n_fail++;
      $display("FAIL done_frozen: got count=%0d end=%b seq=%h want 8/1/%h", count, end_signal, seq_flat, frozen);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(3'b100);
    for (int i = 0; i < 5; i++) rand_press();
    botton = 8'h40;
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    n_cmp++;
    if ({seq_flat, count, end_signal, multi_press, led_echo} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got seq=%h count=%0d end=%b led=%h want all 0", seq_flat, count, end_signal, led_echo);
    end
    botton = '0;
    tick(10);
  endtask

  task automatic test_random();
    logic [2:0] lvls[3] = '{3'b001, 3'b010, 3'b100};
    int np;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      enable = 1'b0;
      tick();
      model_q.delete();
      start(lvls[$urandom_range(0, 2)]);
      np = int'($urandom_range(1, model_target + 3));
      for (int i = 0; i < np; i++) rand_press();
      n_cmp++;
      if (count !== 5'(model_q.size()) || seq_flat !== model_seq() || end_signal !== model_end()) begin
        n_fail++;
        $display("FAIL random_round%0d: got count=%0d end=%b seq=%h want %0d/%b/%h",
                 r, count, end_signal, seq_flat, model_q.size(), model_end(), model_seq());
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; level = '0; botton = '0;
    test_reset();
    test_sequence();
    test_glitch_latency();
    test_arm_hold();
    test_multi();
    test_abort();
    test_done_freeze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
